numa_rx_parser: RTL and testbench

//  Receive-side parser between the GMII RX async FIFO (9-bit, pcie_clk read side) and the

---
 rtl/numa_rx_parser.sv | 271 +++++++++++++++++++++++++++
 tb/tb_numa_rx_parser.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/numa_rx_parser.sv
// numa_rx_parser: strips preamble, filters Ethernet/IPv4/UDP remote-memory-write frames and
// turns each accepted frame into a {sof,eof,data16} write-request stream for the PCIe master.
module numa_rx_parser #(
    parameter logic [15:0] UDP_PORT = 16'h0D5E,
    parameter int unsigned MAX_DW   = 32
) (
    input  logic        pcie_clk,
    input  logic        sys_rst_n,
    input  logic [47:0] if_macaddr,
    input  logic [47:0] mem0_paddr,
    input  logic [8:0]  phy_dout,
    input  logic        phy_empty,
    output logic        phy_rd_en,
    output logic [17:0] mst_din,
    input  logic        mst_full,
    output logic        mst_wr_en,
    output logic [15:0] rx_frames,
    output logic [15:0] drop_frames
);
    localparam int unsigned BC_W      = 6;
    localparam int unsigned LEN_W     = $clog2(MAX_DW + 1);
    localparam int unsigned WC_W      = LEN_W + 1;
    localparam int unsigned HDR_LAST  = 41;
    localparam int unsigned PHDR_LAST = 5;

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_HDR, S_PHDR, S_EMIT, S_DATA, S_PAD, S_TAIL, S_DRAIN
    } state_t;

    state_t            state, state_n;
    logic [BC_W-1:0]   bc, bc_n;
    logic              run;
    logic              vbyte;
    logic              hold_v, hold_v_n;
    logic [8:0]        hold_d, hold_d_n;
    logic              pend_v, pend_v_n;
    logic [17:0]       pend_d, pend_d_n;
    logic              da_uc, da_uc_n, da_bc, da_bc_n;
    logic [39:0]       sr, sr_n;
    logic [31:0]       addr, addr_n;
    logic [LEN_W-1:0]  len, len_n;
    logic [WC_W-1:0]   wc, wc_n;
    logic              phase, phase_n;
    logic [7:0]        hi, hi_n;
    logic [1:0]        ei, ei_n;
    logic [15:0]       rx_n, drop_n;

    logic [8:0]        cur;
    logic              avail, ready, consume, slot_free, wc_last;
    logic [7:0]        mac_byte;
    logic              da_uc_c, da_bc_c, hdr_bad;
    logic [15:0]       len16;
    logic [31:0]       off;
    logic              unused_paddr_hi;

    // Pending byte comes from the skid register first, otherwise straight off the FIFO Q.
    assign cur       = hold_v ? hold_d : phy_dout;
    assign avail     = hold_v || vbyte;
    assign slot_free = !pend_v || !mst_full;
    assign wc_last   = (WC_W'(wc + 1'b1) == {len, 1'b0});
    assign len16     = sr[39:24];
    assign off       = {sr[23:0], cur[7:0]};
    assign mst_din   = pend_d;
    assign mst_wr_en = pend_v && !mst_full;
    assign unused_paddr_hi = ^mem0_paddr[47:32];

    always_comb begin
        case (bc[2:0])
            3'd0:    mac_byte = if_macaddr[47:40];
            3'd1:    mac_byte = if_macaddr[39:32];
            3'd2:    mac_byte = if_macaddr[31:24];
            3'd3:    mac_byte = if_macaddr[23:16];
            3'd4:    mac_byte = if_macaddr[15:8];
            3'd5:    mac_byte = if_macaddr[7:0];
            default: mac_byte = 8'h00;
        endcase
        da_uc_c = da_uc && (cur[7:0] == mac_byte);
        da_bc_c = da_bc && (cur[7:0] == 8'hFF);
        case (bc)
            6'd5:    hdr_bad = !(da_uc_c || da_bc_c);
            6'd12:   hdr_bad = (cur[7:0] != 8'h08);
            6'd13:   hdr_bad = (cur[7:0] != 8'h00);
            6'd14:   hdr_bad = (cur[7:0] != 8'h45);
            6'd23:   hdr_bad = (cur[7:0] != 8'h11);
            6'd36:   hdr_bad = (cur[7:0] != UDP_PORT[15:8]);
            6'd37:   hdr_bad = (cur[7:0] != UDP_PORT[7:0]);
            default: hdr_bad = 1'b0;
        endcase
    end

    // Next-state, datapath and input flow control.
    always_comb begin
        state_n  = state;
        bc_n     = bc;
        pend_v_n = pend_v && mst_full;
        pend_d_n = pend_d;
        da_uc_n  = da_uc;
        da_bc_n  = da_bc;
        sr_n     = sr;
        addr_n   = addr;
        len_n    = len;
        wc_n     = wc;
        phase_n  = phase;
        hi_n     = hi;
        ei_n     = ei;
        rx_n     = rx_frames;
        drop_n   = drop_frames;

        case (state)
            S_EMIT, S_PAD: ready = 1'b0;
            S_DATA:        ready = !cur[8] || !phase || slot_free;
            default:       ready = 1'b1;
        endcase
        consume  = avail && ready;
        hold_v_n = avail && !consume;
        hold_d_n = hold_v_n ? cur : hold_d;

        case (state)
            S_IDLE: if (consume && cur[8]) begin
                if (cur[7:0] == 8'hD5) begin
                    state_n = S_HDR;
                    bc_n    = '0;
                    da_uc_n = 1'b1;
                    da_bc_n = 1'b1;
                end else begin
                    state_n = S_PRE;
                end
            end
            S_PRE: if (consume) begin
                if (!cur[8]) begin
                    state_n = S_IDLE;
                end else if (cur[7:0] == 8'hD5) begin
                    state_n = S_HDR;
                    bc_n    = '0;
                    da_uc_n = 1'b1;
                    da_bc_n = 1'b1;
                end
            end
            S_HDR: if (consume) begin
                da_uc_n = da_uc_c;
                da_bc_n = da_bc_c;
                if (!cur[8]) begin
                    state_n = S_IDLE;
                    drop_n  = drop_frames + 16'd1;
                end else if (hdr_bad) begin
                    state_n = S_DRAIN;
                    drop_n  = drop_frames + 16'd1;
                end else if (bc == BC_W'(HDR_LAST)) begin
                    state_n = S_PHDR;
                    bc_n    = '0;
                end else begin
                    bc_n = BC_W'(bc + 1'b1);
                end
            end
            S_PHDR: if (consume) begin
                if (!cur[8]) begin
                    state_n = S_IDLE;
                    drop_n  = drop_frames + 16'd1;
                end else if (bc == BC_W'(PHDR_LAST)) begin
                    if (len16 == 16'd0 || len16 > 16'(MAX_DW) || off[1:0] != 2'b00) begin
                        state_n = S_DRAIN;
                        drop_n  = drop_frames + 16'd1;
                    end else begin
                        state_n = S_EMIT;
                        addr_n  = mem0_paddr[31:0] + off;
                        len_n   = LEN_W'(len16);
                        ei_n    = 2'd0;
                    end
                end else begin
                    sr_n = {sr[31:0], cur[7:0]};
                    bc_n = BC_W'(bc + 1'b1);
                end
            end
            S_EMIT: if (slot_free) begin
                pend_v_n = 1'b1;
                case (ei)
                    2'd0:    pend_d_n = {2'b10, addr[31:16]};
                    2'd1:    pend_d_n = {2'b00, addr[15:0]};
                    default: pend_d_n = {2'b00, 6'b0, 10'(len)};
                endcase
                if (ei == 2'd2) begin
                    state_n = S_DATA;
                    wc_n    = '0;
                    phase_n = 1'b0;
                    hi_n    = 8'h00;
                end else begin
                    ei_n = 2'(ei + 1'b1);
                end
            end
            S_DATA: if (consume) begin
                if (!cur[8]) begin
                    // A cut mid-word keeps the high byte; PAD emits it with a zero low byte.
                    state_n = S_PAD;
                    if (!phase) hi_n = 8'h00;
                end else if (!phase) begin
                    hi_n    = cur[7:0];
                    phase_n = 1'b1;
                end else begin
                    pend_v_n = 1'b1;
                    pend_d_n = {1'b0, wc_last, hi, cur[7:0]};
                    phase_n  = 1'b0;
                    wc_n     = WC_W'(wc + 1'b1);
                    if (wc_last) begin
                        state_n = S_TAIL;
                        rx_n    = rx_frames + 16'd1;
                    end
                end
            end
            S_PAD: if (slot_free) begin
                pend_v_n = 1'b1;
                pend_d_n = {1'b0, wc_last, hi, 8'h00};
                hi_n     = 8'h00;
                wc_n     = WC_W'(wc + 1'b1);
                if (wc_last) begin
                    state_n = S_IDLE;
                    drop_n  = drop_frames + 16'd1;
                end
            end
            S_TAIL, S_DRAIN: if (consume && !cur[8]) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Only fetch when the skid register is guaranteed free for the returning byte.
        phy_rd_en = run && !phy_empty && !(mst_full && pend_v) &&
                    (state != S_EMIT) && (state != S_PAD) && !hold_v_n;
    end

    always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            bc          <= '0;
            run         <= 1'b0;
            vbyte       <= 1'b0;
            hold_v      <= 1'b0;
            hold_d      <= '0;
            pend_v      <= 1'b0;
            pend_d      <= '0;
            da_uc       <= 1'b0;
            da_bc       <= 1'b0;
            sr          <= '0;
            addr        <= '0;
            len         <= '0;
            wc          <= '0;
            phase       <= 1'b0;
            hi          <= '0;
            ei          <= '0;
            rx_frames   <= '0;
            drop_frames <= '0;
        end else begin
            state       <= state_n;
            bc          <= bc_n;
            run         <= 1'b1;
            vbyte       <= phy_rd_en;
            hold_v      <= hold_v_n;
            hold_d      <= hold_d_n;
            pend_v      <= pend_v_n;
            pend_d      <= pend_d_n;
            da_uc       <= da_uc_n;
            da_bc       <= da_bc_n;
            sr          <= sr_n;
            addr        <= addr_n;
            len         <= len_n;
            wc          <= wc_n;
            phase       <= phase_n;
            hi          <= hi_n;
            ei          <= ei_n;
            rx_frames   <= rx_n;
            drop_frames <= drop_n;
        end
    end
endmodule

// File: tb/tb_numa_rx_parser.sv
// Randomized scoreboard bench for numa_rx_parser: a frame-level reference model predicts
// the write-request words and frame counters from the header fields it generates.
module tb_numa_rx_parser;
    localparam logic [47:0] MAC  = 48'h02_11_22_33_44_55;
    localparam logic [15:0] PORT = 16'h0D5E;

    logic        pcie_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [47:0] if_macaddr = MAC;
    logic [47:0] mem0_paddr = 48'h0;
    logic [8:0]  phy_dout = 9'h0;
    logic        phy_empty = 1'b1;
    logic        phy_rd_en;
    logic [17:0] mst_din;
    logic        mst_full = 1'b0;
    logic        mst_wr_en;
    logic [15:0] rx_frames, drop_frames;

    numa_rx_parser dut (
        .pcie_clk(pcie_clk), .sys_rst_n(sys_rst_n), .if_macaddr(if_macaddr),
        .mem0_paddr(mem0_paddr), .phy_dout(phy_dout), .phy_empty(phy_empty),
        .phy_rd_en(phy_rd_en), .mst_din(mst_din), .mst_full(mst_full),
        .mst_wr_en(mst_wr_en), .rx_frames(rx_frames), .drop_frames(drop_frames)
    );

    always #5 pcie_clk = ~pcie_clk;

    logic [8:0]  src_q[$];
    logic [17:0] exp_q[$];
    logic [7:0]  pay_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          words_seen = 0;
    int          full_mode = 0;
    bit          bubble_en = 1'b0;
    logic [15:0] m_rx = 16'd0;
    logic [15:0] m_drop = 16'd0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // RX FIFO model: Q appears the cycle after a read.
    always @(posedge pcie_clk) begin
        if (!sys_rst_n) begin
            phy_empty <= 1'b1;
        end else begin
            if (phy_rd_en && src_q.size() > 0) phy_dout <= src_q.pop_front();
            phy_empty <= (src_q.size() == 0) || (bubble_en && ($urandom % 4 == 0));
        end
    end

    always @(posedge pcie_clk) begin
        #1;
        case (full_mode)
            0:       mst_full = 1'b0;
            1:       mst_full = ($urandom % 3 == 0);
            default: mst_full = 1'b1;
        endcase
    end

    // Monitor: every written word is popped from the scoreboard and compared.
    always @(negedge pcie_clk) begin
        if (sys_rst_n && mst_wr_en) begin
            check("no_write_when_full", 48'(mst_full), 48'd0);
            words_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got %0h expected none", mst_din);
            end else begin
                check("mst_din", 48'(mst_din), 48'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] ver,
                              input logic [7:0] pr, input logic [15:0] port,
                              input logic [15:0] len_dw, input logic [31:0] off, input int cut);
        logic [7:0]  fb[$];
        logic [31:0] addr;
        logic [7:0]  b0, b1;
        int          kept, n, npre;
        bit          ok;
        for (int i = 0; i < 6; i++) fb.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fb.push_back(8'($urandom));
        fb.push_back(et[15:8]); fb.push_back(et[7:0]); fb.push_back(ver);
        for (int i = 0; i < 8; i++) fb.push_back(8'($urandom));
        fb.push_back(pr);
        for (int i = 0; i < 12; i++) fb.push_back(8'($urandom));
        fb.push_back(port[15:8]); fb.push_back(port[7:0]);
        for (int i = 0; i < 4; i++) fb.push_back(8'($urandom));
        fb.push_back(len_dw[15:8]); fb.push_back(len_dw[7:0]);
        for (int i = 0; i < 4; i++) fb.push_back(off[31-8*i -: 8]);
        foreach (pay_q[i]) fb.push_back(pay_q[i]);
        for (int i = 0; i < 4; i++) fb.push_back(8'($urandom));
        kept = (cut < 0 || cut > fb.size()) ? fb.size() : cut;

        // Frame-level reference model.
        ok = (dst == MAC || dst == 48'hFFFF_FFFF_FFFF) && et == 16'h0800 && ver == 8'h45 &&
             pr == 8'h11 && port == PORT && len_dw != 0 && len_dw <= 32 && off[1:0] == 2'b00;
        if (!ok || kept < 48) begin
            m_drop++;
        end else begin
            addr = mem0_paddr[31:0] + off;
            exp_q.push_back({2'b10, addr[31:16]});
            exp_q.push_back({2'b00, addr[15:0]});
            exp_q.push_back({8'h00, len_dw[9:0]});
            n = kept - 48;
            if (n > 4 * int'(len_dw)) n = 4 * int'(len_dw);
            for (int k = 0; k < 2 * int'(len_dw); k++) begin
                b0 = (2 * k < n) ? pay_q[2*k] : 8'h00;
                b1 = (2 * k + 1 < n) ? pay_q[2*k+1] : 8'h00;
                exp_q.push_back({1'b0, k == 2 * int'(len_dw) - 1, b0, b1});
            end
            if (n == 4 * int'(len_dw)) m_rx++;
            else m_drop++;
        end

        @(negedge pcie_clk);
        npre = $urandom % 8;
        for (int i = 0; i < npre; i++) src_q.push_back(9'h155);
        src_q.push_back(9'h1D5);
        for (int i = 0; i < kept; i++) src_q.push_back({1'b1, fb[i]});
        for (int i = 0; i <= int'($urandom % 3); i++) src_q.push_back({1'b0, 8'($urandom)});
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && t < 6000) begin
            @(negedge pcie_clk);
            t++;
        end
        if (t >= 6000) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d bytes %0d words pending expected 0", src_q.size(), exp_q.size());
            src_q.delete();
            exp_q.delete();
        end
        repeat (8) @(negedge pcie_clk);
    endtask

    task automatic check_counters();
        check("rx_frames", 48'(rx_frames), 48'(m_rx));
        check("drop_frames", 48'(drop_frames), 48'(m_drop));
    endtask

    task automatic fill_pay(input int nb);
        pay_q.delete();
        for (int i = 0; i < nb; i++) pay_q.push_back(8'($urandom));
    endtask

    task automatic wait_words(input int cnt);
        int base = words_seen;
        int t = 0;
        while (words_seen < base + cnt && t < 2000) begin
            @(negedge pcie_clk);
            t++;
        end
        if (t >= 2000) begin
            n_checks++;
            $display("FAIL word_wait_timeout: got %0d words expected %0d", words_seen - base, cnt);
        end
    endtask

    initial begin
        logic [47:0] dst;
        logic [15:0] et, port, len;
        logic [7:0]  ver, pr;
        logic [31:0] off, tmp;
        int          cut, rd_cnt;

        repeat (3) @(negedge pcie_clk);
        check("reset_rd_en", 48'(phy_rd_en), 48'd0);
        check("reset_wr_en", 48'(mst_wr_en), 48'd0);
        check("reset_mst_din", 48'(mst_din), 48'd0);
        check_counters();
        sys_rst_n = 1'b1;
        repeat (2) @(negedge pcie_clk);

        // Basic accepted frame.
        mem0_paddr = 48'h0000_D000_0000;
        pay_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(MAC, 16'h0800, 8'h45, 8'h11, PORT, 16'd1, 32'h10, -1);
        wait_idle();
        check_counters();

        // Wrong UDP port is dropped, following frame accepted.
        send_frame(MAC, 16'h0800, 8'h45, 8'h11, 16'h0D5F, 16'd1, 32'h10, -1);
        wait_idle();
        check_counters();
        send_frame(MAC, 16'h0800, 8'h45, 8'h11, PORT, 16'd1, 32'h10, -1);
        wait_idle();
        check_counters();

        // Frame cut after 3 payload bytes is padded to full length.
        fill_pay(16);
        send_frame(MAC, 16'h0800, 8'h45, 8'h11, PORT, 16'd4, 32'h40, 48 + 3);
        wait_idle();
        check_counters();

        // Back-pressure held mid-payload stalls the input.
        fill_pay(128);
        send_frame(48'hFFFF_FFFF_FFFF, 16'h0800, 8'h45, 8'h11, PORT, 16'd32, 32'h100, -1);
        wait_words(6);
        full_mode = 2;
        rd_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge pcie_clk);
            if (i >= 5 && phy_rd_en) rd_cnt++;
        end
        full_mode = 0;
        check("rd_en_low_while_full", 48'(rd_cnt), 48'd0);
        wait_idle();
        check_counters();

        // Address addition wraps at 2^32.
        mem0_paddr = 48'h0000_FFFF_FFF0;
        fill_pay(8);
        send_frame(MAC, 16'h0800, 8'h45, 8'h11, PORT, 16'd2, 32'h20, -1);
        wait_idle();
        check_counters();

        // Reset mid-payload abandons the frame; next frame is intact.
        fill_pay(128);
        send_frame(MAC, 16'h0800, 8'h45, 8'h11, PORT, 16'd32, 32'h0, -1);
        wait_words(8);
        sys_rst_n = 1'b0;
        src_q.delete();
        exp_q.delete();
        m_rx = 16'd0;
        m_drop = 16'd0;
        repeat (3) @(negedge pcie_clk);
        check_counters();
        check("reset_mid_wr_en", 48'(mst_wr_en), 48'd0);
        sys_rst_n = 1'b1;
        @(negedge pcie_clk);
        fill_pay(12);
        send_frame(MAC, 16'h0800, 8'h45, 8'h11, PORT, 16'd3, 32'h8, -1);
        wait_idle();
        check_counters();

        // Randomized frames with random back-pressure and FIFO bubbles.
        full_mode = 1;
        bubble_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            tmp = $urandom;
            mem0_paddr = {16'($urandom), tmp};
            dst = MAC; et = 16'h0800; ver = 8'h45; pr = 8'h11; port = PORT;
            len = 16'(1 + $urandom % 32);
            tmp = $urandom;
            off = {tmp[31:2], 2'b00};
            cut = -1;
            case ($urandom % 12)
                1:  dst = dst ^ (48'd1 << ($urandom % 48));
                2:  dst = 48'hFFFF_FFFF_FFFF;
                3:  et = 16'h86DD;
                4:  ver = 8'h46;
                5:  pr = 8'h06;
                6:  port = port ^ (16'd1 << ($urandom % 16));
                7:  len = 16'd0;
                8:  len = 16'(33 + $urandom % 100);
                9:  off[1:0] = 2'(1 + $urandom % 3);
                10: cut = int'($urandom % 48);
                11: cut = 48 + int'($urandom % (4 * int'(len)));
                default: ;
            endcase
            fill_pay((len >= 1 && len <= 32) ? 4 * int'(len) : 8);
            send_frame(dst, et, ver, pr, port, len, off, cut);
            wait_idle();
            check_counters();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
